// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a line-oriented memory bus.
// One transaction is in flight at a time: a command cycle, write beats or read beats, then a done pulse.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int LINE_BYTES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        req_i,
  input  logic [1:0]        cmd0_i,
  input  logic [1:0]        cmd1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        wr_ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rd_valid_o,
  output logic [1:0]        done_o,
  output logic [1:0]        mem_cmd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wvalid_o,
  input  logic              mem_resp_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
);

  localparam int BEATS = LINE_BYTES * 8 / DATA_W;
  localparam int CNT_W = $clog2(BEATS) + 1;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WDATA,
    WAIT_RESP,
    RDATA,
    DONE
  } state_t;

  state_t            state_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [1:0]        cmd_reg;
  logic [CNT_W-1:0]  beat_reg;

  logic              qual0;
  logic              qual1;
  logic              grant_sel;
  logic [1:0]        owner_bit;
  logic              last_beat;

  // Only READ_LINE (10) and WRITE_LINE (11) qualify; both have bit 1 set.
  assign qual0     = req_i[0] & cmd0_i[1];
  assign qual1     = req_i[1] & cmd1_i[1];
  assign grant_sel = (qual0 & qual1) ? ~last_grant_reg : qual1;
  assign owner_bit = owner_reg ? 2'b10 : 2'b01;
  assign last_beat = (beat_reg == CNT_W'(BEATS - 1));

  // Write data passes straight through from the owner while beats are being accepted.
  assign mem_wdata_o = mem_wvalid_o ? (owner_reg ? wdata1_i : wdata0_i) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cmd_reg        <= CMD_NOP;
      beat_reg       <= '0;
      mem_cmd_o      <= CMD_NOP;
      mem_addr_o     <= '0;
      mem_wvalid_o   <= 1'b0;
      wr_ready_o     <= 2'b00;
      rdata_o        <= '0;
      rd_valid_o     <= 2'b00;
      done_o         <= 2'b00;
    end else begin
      mem_cmd_o  <= CMD_NOP;
      rd_valid_o <= 2'b00;
      done_o     <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (qual0 | qual1) begin
            owner_reg  <= grant_sel;
            cmd_reg    <= grant_sel ? cmd1_i : cmd0_i;
            mem_cmd_o  <= grant_sel ? cmd1_i : cmd0_i;
            mem_addr_o <= grant_sel ? addr1_i : addr0_i;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          beat_reg <= '0;
          if (cmd_reg == CMD_WRITE) begin
            wr_ready_o   <= owner_bit;
            mem_wvalid_o <= 1'b1;
            state_reg    <= WDATA;
          end else begin
            state_reg <= WAIT_RESP;
          end
        end
        WDATA: begin
          beat_reg <= beat_reg + CNT_W'(1);
          if (last_beat) begin
            beat_reg     <= '0;
            wr_ready_o   <= 2'b00;
            mem_wvalid_o <= 1'b0;
            state_reg    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_i) begin
            if (cmd_reg == CMD_WRITE) begin
              done_o    <= owner_bit;
              state_reg <= DONE;
            end else begin
              state_reg <= RDATA;
            end
          end
        end
        RDATA: begin
          if (mem_rvalid_i) begin
            rdata_o    <= mem_rdata_i;
            rd_valid_o <= owner_bit;
            beat_reg   <= beat_reg + CNT_W'(1);
            if (last_beat) begin
              done_o    <= owner_bit;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          // Requests are deliberately not looked at here; arbitration resumes in IDLE.
          last_grant_reg <= owner_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
